// File: rtl/fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_unit
//
// Instruction fetch stage with a prefetch buffer. Fetches are issued over a
// req/gnt/rvalid handshake with at most one request outstanding, so the
// instruction memory may have any response latency. Returned instructions are
// queued in a DEPTH-entry FIFO and offered to the FD pipe register as
// {pc_plus_inc, instruction} under valid/ready. A branch flush redirects the
// PC, empties the FIFO and marks any in-flight response stale so that it is
// dropped. Fetching a HALT opcode freezes fetch until the next flush or reset.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   flush            redirect fetch to branch_target, clear the FIFO
//   branch_target    redirect address
//   imem_req/addr    fetch request and its address (addr == pc)
//   imem_gnt         memory accepts the request this cycle
//   imem_rvalid/rdata response strobe and instruction
//   out_valid/ready  FIFO head handshake towards the FD register
//   F_out            FIFO head {pc_plus_inc, instruction}
//   pc               next fetch address
//   halted           fetch frozen by a HALT opcode
//   occupancy        number of buffered entries
// -----------------------------------------------------------------------------
module fetch_prefetch_unit #(
   parameter int unsigned     PC_W     = 16,
   parameter int unsigned     INSTR_W  = 16,
   parameter int unsigned     DEPTH    = 4,
   parameter int unsigned     PC_INC   = 2,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
   parameter logic [3:0]      HALT_OPC = 4'hF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic [PC_W-1:0]               branch_target,
   output logic                          imem_req,
   output logic [PC_W-1:0]               imem_addr,
   input  logic                          imem_gnt,
   input  logic                          imem_rvalid,
   input  logic [INSTR_W-1:0]            imem_rdata,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [PC_W+INSTR_W-1:0]       F_out,
   output logic [PC_W-1:0]               pc,
   output logic                          halted,
   output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

   localparam int unsigned ENTRY_W = PC_W + INSTR_W;
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam logic [PC_W-1:0]  INC_C   = PC_W'(PC_INC);
   localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

   function automatic logic is_halt_opc(input logic [INSTR_W-1:0] instr);
      return (instr[INSTR_W-1 -: 4] == HALT_OPC);
   endfunction

   logic [PC_W-1:0]    pc_r;
   logic [PC_W-1:0]    req_pc_r;
   logic               pending_r;
   logic               stale_r;
   logic               halted_r;
   logic               out_valid_r;
   logic [CNT_W-1:0]   count_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [ENTRY_W-1:0] mem_r [DEPTH];
   logic [ENTRY_W-1:0] head_r;

   logic               rsp_s;
   logic               push_s;
   logic               pop_s;
   logic               halt_rdata_s;
   logic               slot_ok_s;
   logic               req_s;
   logic               accept_s;
   logic [ENTRY_W-1:0] push_data_s;
   logic [CNT_W-1:0]   count_next_s;
   logic [ENTRY_W-1:0] head_next_s;

   // Handshake decode: response, push/pop and request issue conditions.
   always_comb begin
      rsp_s        = imem_rvalid && pending_r;
      push_s       = rsp_s && !stale_r && !flush;
      pop_s        = out_valid_r && out_ready && !flush;
      halt_rdata_s = is_halt_opc(imem_rdata);
      // The outstanding request already owns a slot, so a push can never overflow.
      slot_ok_s    = (({1'b0, count_r} + {{CNT_W{1'b0}}, pending_r}) < DEPTH_C);
      req_s        = !flush && !halted_r && (!pending_r || imem_rvalid)
                     && !(imem_rvalid && halt_rdata_s) && slot_ok_s;
      accept_s     = req_s && imem_gnt;
      push_data_s  = {req_pc_r + INC_C, imem_rdata};
   end

   // Next occupancy and next registered head entry.
   always_comb begin
      count_next_s = count_r;
      head_next_s  = head_r;
      if (flush) begin
         count_next_s = {CNT_W{1'b0}};
      end else begin
         case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
         endcase
         // Head tracks the oldest entry; a push into an empty (or emptying)
         // FIFO bypasses straight into the head register.
         if (pop_s && (count_r > CNT_W'(1))) begin
            head_next_s = mem_r[rd_ptr_r + PTR_W'(1)];
         end else if (push_s && (pop_s || (count_r == {CNT_W{1'b0}}))) begin
            head_next_s = push_data_s;
         end else begin
            head_next_s = head_r;
         end
      end
   end

   // FIFO storage; pointers reset with the control state so contents need no reset.
   always_ff @(posedge clk) begin
      if (rst_n && push_s) begin
         mem_r[wr_ptr_r] <= push_data_s;
      end
   end

   // Fetch control, FIFO pointers and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_r        <= RESET_PC;
         req_pc_r    <= RESET_PC;
         pending_r   <= 1'b0;
         stale_r     <= 1'b0;
         halted_r    <= 1'b0;
         out_valid_r <= 1'b0;
         count_r     <= {CNT_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         wr_ptr_r    <= {PTR_W{1'b0}};
         head_r      <= {ENTRY_W{1'b0}};
      end else begin
         count_r     <= count_next_s;
         out_valid_r <= (count_next_s != {CNT_W{1'b0}});
         head_r      <= head_next_s;
         if (flush) begin
            pc_r      <= branch_target;
            rd_ptr_r  <= {PTR_W{1'b0}};
            wr_ptr_r  <= {PTR_W{1'b0}};
            halted_r  <= 1'b0;
            // A request still in flight stays pending but its data is dropped.
            pending_r <= pending_r && !imem_rvalid;
            stale_r   <= pending_r && !imem_rvalid;
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s && halt_rdata_s) begin
               halted_r <= 1'b1;
            end
            if (accept_s) begin
               pending_r <= 1'b1;
               stale_r   <= 1'b0;
               req_pc_r  <= pc_r;
               pc_r      <= pc_r + INC_C;
            end else if (rsp_s) begin
               pending_r <= 1'b0;
               stale_r   <= 1'b0;
            end
         end
      end
   end

   assign imem_req  = req_s;
   assign imem_addr = pc_r;
   assign out_valid = out_valid_r;
   assign F_out     = head_r;
   assign pc        = pc_r;
   assign halted    = halted_r;
   assign occupancy = count_r;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_prefetch_unit
//
// Self-checking bench. A behavioural instruction memory with programmable
// latency grants requests; every accepted fetch pushes the expected FIFO entry
// {addr+2, instr_at(addr)} onto a scoreboard queue, which is cleared on flush
// and reset. A monitor pops and compares whenever the DUT hands an entry over.
// A second instance with RESET_PC=0xFFFE covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [15:0] branch_target;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] F_out;
   logic [15:0] pc;
   logic        halted;
   logic [2:0]  occupancy;

   logic        w_imem_req;
   logic [15:0] w_imem_addr;
   logic        w_imem_gnt;
   logic        w_imem_rvalid;
   logic [15:0] w_imem_rdata;
   logic        w_out_valid;
   logic        w_out_ready;
   logic [31:0] w_F_out;
   logic [15:0] w_pc;
   logic        w_halted;
   logic [2:0]  w_occupancy;
   logic        w_flush;
   logic [15:0] w_branch_target;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          mem_lat = 1;
   int          mem_cnt = 0;
   int          fire_cnt = 0;
   int          pops = 0;
   logic        gnt_en = 1'b0;
   logic        halt_en = 1'b0;
   logic [15:0] mem_addr = 16'h0000;
   logic [15:0] last_fire_addr = 16'h0000;
   logic [31:0] last_pop = 32'h0000_0000;
   logic [31:0] sb_q [$];

   always #5 clk = ~clk;

   fetch_prefetch_unit u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .F_out(F_out),
      .pc(pc), .halted(halted), .occupancy(occupancy)
   );

   fetch_prefetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
      .clk(clk), .rst_n(rst_n), .flush(w_flush), .branch_target(w_branch_target),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(w_imem_gnt),
      .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .F_out(w_F_out),
      .pc(w_pc), .halted(w_halted), .occupancy(w_occupancy)
   );

   function automatic logic [15:0] instr_at(input logic [15:0] a);
      if (halt_en && (a == 16'h000A)) return 16'hF123;
      return {4'h3, a[11:0] ^ 12'h5A5};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Instruction memory model: drives responses at the falling edge, records grants.
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'h0000;
      imem_gnt    = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_cnt > 0) begin
            mem_cnt--;
            imem_rvalid = (mem_cnt == 0);
            imem_rdata  = (mem_cnt == 0) ? instr_at(mem_addr) : 16'h0000;
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'h0000;
         end
         #1 imem_gnt = gnt_en;
         #1;
         if (imem_req && imem_gnt && rst_n) begin
            mem_addr       = imem_addr;
            mem_cnt        = mem_lat;
            last_fire_addr = imem_addr;
            fire_cnt++;
            sb_q.push_back({imem_addr + 16'd2, instr_at(imem_addr)});
         end
      end
   end

   // Output monitor: every accepted FIFO entry must match the scoreboard head.
   initial begin
      logic [31:0] exp_v;
      forever begin
         @(negedge clk);
         #3;
         if (rst_n && !flush && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_underflow", 32'(out_valid), 32'd0);
            end else begin
               exp_v = sb_q.pop_front();
               check_eq("sb_entry", F_out, exp_v);
               last_pop = F_out;
               pops++;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      flush = 1'b0;
      sb_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n = 1'b0; flush = 1'b0; branch_target = 16'h0000; out_ready = 1'b1;
      w_imem_gnt = 1'b1; w_imem_rvalid = 1'b0; w_imem_rdata = 16'h0000;
      w_out_ready = 1'b0; w_flush = 1'b0; w_branch_target = 16'h0000;

      // 1: streaming with a 1-cycle memory
      gnt_en = 1'b1; mem_lat = 1; out_ready = 1'b1;
      do_reset();
      #4;
      check_eq("rst_occ", 32'(occupancy), 32'd0);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_pc", 32'(pc), 32'h0000);
      check_eq("rst_halted", 32'(halted), 32'd0);
      for (int c = 0; c < 4; c++) begin
         check_eq("t1_req", 32'(imem_req), 32'd1);
         check_eq("t1_addr", 32'(imem_addr), 32'(2 * c));
         if (c == 2) check_eq("t1_fout_c2", F_out, {16'h0002, instr_at(16'h0000)});
         if (c == 3) check_eq("t1_fout_c3", F_out, {16'h0004, instr_at(16'h0002)});
         @(negedge clk); #4;
      end
      repeat (6) @(negedge clk);

      // 2: backpressure fills the FIFO, then drains in order at full rate
      out_ready = 1'b0;
      do_reset();
      repeat (12) @(negedge clk);
      #4;
      check_eq("t2_occ", 32'(occupancy), 32'd4);
      check_eq("t2_req", 32'(imem_req), 32'd0);
      check_eq("t2_hold", F_out, {16'h0002, instr_at(16'h0000)});
      check_eq("t2_fetches", 32'(sb_q.size()), 32'd4);
      @(negedge clk);
      out_ready = 1'b1;
      base = pops;
      repeat (8) @(negedge clk);
      #4;
      check_eq("t2_drain_rate", 32'((pops - base) >= 8), 32'd1);

      // 3: flush with a 3-cycle response in flight
      mem_lat = 3;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #3;
         if (last_fire_addr == 16'h0008) break;
      end
      check_eq("t3_reach8", 32'(last_fire_addr), 32'h0008);
      @(negedge clk);
      flush = 1'b1; branch_target = 16'h0040; sb_q.delete();
      #4 check_eq("t3_req_in_flush", 32'(imem_req), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #4;
      check_eq("t3_occ", 32'(occupancy), 32'd0);
      check_eq("t3_valid", 32'(out_valid), 32'd0);
      check_eq("t3_pc", 32'(pc), 32'h0040);
      check_eq("t3_wait_stale", 32'(imem_req), 32'd0);
      for (int i = 0; i < 20; i++) begin
         if (out_valid) break;
         @(negedge clk); #4;
      end
      check_eq("t3_first_valid", 32'(out_valid), 32'd1);
      check_eq("t3_first_entry", F_out, {16'h0042, instr_at(16'h0040)});

      // 4: HALT freezes fetch; flush resumes
      mem_lat = 1; halt_en = 1'b1;
      do_reset();
      repeat (15) @(negedge clk);
      #4;
      check_eq("t4_halted", 32'(halted), 32'd1);
      check_eq("t4_req", 32'(imem_req), 32'd0);
      check_eq("t4_drained", 32'(out_valid), 32'd0);
      check_eq("t4_last_fetch", 32'(last_fire_addr), 32'h000A);
      check_eq("t4_last_entry", last_pop, {16'h000C, 16'hF123});
      @(negedge clk);
      flush = 1'b1; branch_target = 16'h0020; sb_q.delete();
      @(negedge clk);
      flush = 1'b0;
      #4;
      check_eq("t4_unhalt", 32'(halted), 32'd0);
      check_eq("t4_resume_req", 32'(imem_req), 32'd1);
      check_eq("t4_resume_addr", 32'(imem_addr), 32'h0020);
      @(negedge clk);
      @(negedge clk);
      #4;
      check_eq("t4_resume_entry", F_out, {16'h0022, instr_at(16'h0020)});
      halt_en = 1'b0;

      // 5: reset with a request pending and three entries buffered
      mem_lat = 3; out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #4;
         if ((occupancy == 3'd3) && (mem_cnt > 0)) break;
      end
      check_eq("t5_setup", 32'(occupancy), 32'd3);
      @(negedge clk);
      rst_n = 1'b0; gnt_en = 1'b0; sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #4;
      check_eq("t5_occ", 32'(occupancy), 32'd0);
      check_eq("t5_valid", 32'(out_valid), 32'd0);
      check_eq("t5_pc", 32'(pc), 32'h0000);
      repeat (4) @(negedge clk);
      #4;
      check_eq("t5_no_push", 32'(occupancy), 32'd0);
      check_eq("t5_valid_late", 32'(out_valid), 32'd0);
      check_eq("t5_req_held", 32'(imem_req), 32'd1);
      check_eq("t5_addr_stable", 32'(imem_addr), 32'h0000);

      // 6: PC wrap on the RESET_PC=0xFFFE instance
      gnt_en = 1'b1; mem_lat = 1; out_ready = 1'b1;
      do_reset();
      #4;
      check_eq("t6_addr0", 32'(w_imem_addr), 32'h0000_FFFE);
      check_eq("t6_req0", 32'(w_imem_req), 32'd1);
      @(negedge clk);
      w_imem_rvalid = 1'b1; w_imem_rdata = instr_at(16'hFFFE);
      #4;
      check_eq("t6_addr1", 32'(w_imem_addr), 32'h0000);
      @(negedge clk);
      w_imem_rvalid = 1'b0; w_imem_rdata = 16'h0000;
      #4;
      check_eq("t6_valid", 32'(w_out_valid), 32'd1);
      check_eq("t6_entry", w_F_out, {16'h0000, instr_at(16'hFFFE)});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised successor to the single-cycle fetch stage. It issues instruction fetches over a request/grant/response handshake, so variable-latency instruction memory or a cache is supported. Returned instructions are buffered in a DEPTH-entry prefetch FIFO, and each entry is presented to the FD pipe register as {pc_plus_inc, instruction} under a valid/ready handshake. The block supports branch-redirect flush with stale-response discard, and HALT-opcode fetch freeze.

Parameters:
PC_W, 16, width of PC and branch target.
INSTR_W, 16, instruction width; the opcode is instr[INSTR_W-1 -: 4].
DEPTH, 4, prefetch FIFO entries (power of two, at least 2).
PC_INC, 2, PC increment per instruction.
RESET_PC, 0, PC value after reset.
HALT_OPC, 4'hF, opcode that freezes fetch.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
flush  in  1  branch taken in decode; redirect fetch to branch_target.
branch_target  in  PC_W  redirect address, valid when flush=1.
imem_req  out  1  fetch request.
imem_addr  out  PC_W  fetch address; equals pc.
imem_gnt  in  1  memory accepts the request this cycle (handshake is req&gnt).
imem_rvalid  in  1  response valid.
imem_rdata  in  INSTR_W  response instruction.
out_valid  out  1  FIFO head valid.
out_ready  in  1  FD register accepts (0 = stall from hazard unit).
F_out  out  PC_W+INSTR_W  FIFO head: {pc_plus_inc, instruction}.
pc  out  PC_W  next fetch address.
halted  out  1  fetch frozen by HALT.
occupancy  out  $clog2(DEPTH+1)  FIFO entry count.

Behaviour:
- Reset (rst_n=0 at an edge): pc=RESET_PC, FIFO empty, occupancy=0, out_valid=0, pending=0, stale=0, halted=0. Reset overrides every other input, including a response or request in flight. A response arriving after reset is ignored because pending=0.
- Internal state: pending (one outstanding request max), req_pc (address of the outstanding request), stale (the outstanding response must be dropped).
- imem_req is combinational: !flush && !halted && (!pending || imem_rvalid) && !(imem_rvalid && rdata opcode==HALT_OPC) && (occupancy + pending < DEPTH).
- Request accepted (imem_req && imem_gnt): pending=1, stale=0, req_pc=pc, pc=pc+PC_INC (wraps modulo 2^PC_W). imem_req may stay high without a grant; addr must remain stable until granted.
- Response (imem_rvalid && pending): pending clears unless a new request is granted in the same cycle.
  - If stale=0 and flush=0, push {req_pc+PC_INC, imem_rdata}.
  - If the pushed opcode is HALT_OPC, set halted=1. The HALT instruction itself is still pushed.
- imem_rvalid with pending=0 is ignored.
- Pop: when out_valid && out_ready, the head is removed. Push and pop in the same cycle leave occupancy unchanged. A push is never lost: the issue condition reserves a slot.
- Latency: with a 1-cycle memory (gnt at N, rvalid at N+1), the entry is visible on F_out at N+2. Steady-state throughput is 1 instruction/cycle.
- Flush (highest priority after reset):
  - pc=branch_target; FIFO cleared (occupancy=0, out_valid=0 next cycle); halted=0; no request issued that cycle.
  - A pop in the same cycle is discarded.
  - A response arriving in the same cycle is dropped.
  - If a request is outstanding and not returned, stale=1; its response is dropped and clears pending and stale.
- HALT: while halted=1, no requests. Buffered entries still drain. Only flush or reset clears halted, which matches the branch-shadow rule.
- out_valid is 1 iff occupancy>0. F_out is registered FIFO read data, stable while out_valid && !out_ready.

Test Plan:
1. Stream with a 1-cycle memory: gnt=1 always, out_ready=1, RESET_PC=0. Required: addresses 0,2,4,6 on consecutive cycles. F_out is {0x0002,I0} at cycle 2, then {0x0004,I1} and onward, one per cycle.
2. Backpressure: out_ready=0 from cycle 3. Required: occupancy saturates at 4; imem_req drops; F_out holds {0x0002,I0}. Raising out_ready drains entries in order with no loss or duplication.
3. Flush with a 3-cycle-latency response in flight: pc=0x0008 pending, flush with target 0x0040. Required: the late response for 0x0008 is dropped; FIFO empties; next request is 0x0040; first F_out is {0x0042,instr@0x40}.
4. HALT: opcode 0xF at 0x000A. Required: halted=1, no request after it, F_out emits {0x000C,0xF...} last. A later flush to 0x0020 clears halted and resumes at 0x0020.
5. Reset mid-operation: rst_n=0 with pending=1 and occupancy=3. Required: next cycle occupancy=0, out_valid=0, pc=RESET_PC. The subsequent rvalid produces no push.
6. PC wrap: RESET_PC=0xFFFE. Required: addresses 0xFFFE then 0x0000; first entry is {0x0000,instr@0xFFFE}.
